// File: rtl/axilite_regfile_slave.sv
// -----------------------------------------------------------------------------
// axilite_regfile_slave
//
// AXI4-Lite slave register file. NUM_REGS read/write 32-bit registers sit at
// word offsets 0x00 upward. A read-only write counter (WCOUNT) follows them
// directly. Any other word index is undecoded and answers SLVERR.
//
// Ports
//   ACLK, ARESETN            clock (rising edge), asynchronous active-low reset
//   S_AXI_AW* (ADDR/PROT/VALID/READY)   write address channel (PROT ignored)
//   S_AXI_W*  (DATA/STRB/VALID/READY)   write data channel
//   S_AXI_B*  (RESP/VALID/READY)        write response channel
//   S_AXI_AR* (ADDR/PROT/VALID/READY)   read address channel (PROT ignored)
//   S_AXI_R*  (DATA/RESP/VALID/READY)   read data channel
//
// Handshake rule (applies to every channel): a beat transfers on a rising
// ACLK edge where VALID and READY are both 1. A source holds VALID and its
// payload stable until that edge, and this slave holds BVALID/RVALID and their
// payloads stable until BREADY/RREADY. All READY outputs are registered.
//
// The write FSM state (wr_state_q) and read FSM state (rd_state_q) are
// the actual state registers. Probes can bind to them directly.
// -----------------------------------------------------------------------------
module axilite_regfile_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int DW    = C_S_AXI_DATA_WIDTH;
    localparam int AW    = C_S_AXI_ADDR_WIDTH;
    localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [IDX_W-1:0] WCOUNT_IDX = IDX_W'(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write FSM: which half of a write is latched, or response outstanding.
    localparam logic [1:0] WR_IDLE    = 2'd0;
    localparam logic [1:0] WR_HAVE_AW = 2'd1;
    localparam logic [1:0] WR_HAVE_W  = 2'd2;
    localparam logic [1:0] WR_RESP    = 2'd3;

    // Read FSM
    localparam logic [0:0] RD_IDLE = 1'b0;
    localparam logic [0:0] RD_RESP = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]    wr_state_q, wr_state_d;
    logic          awready_q, awready_d;
    logic          wready_q, wready_d;
    logic [AW-1:0] aw_addr_q, aw_addr_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic [SW-1:0] w_strb_q, w_strb_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [DW-1:0] regs_q [NUM_REGS];
    logic [DW-1:0] regs_d [NUM_REGS];
    logic [DW-1:0] wcount_q, wcount_d;

    logic [0:0]    rd_state_q, rd_state_d;
    logic          arready_q, arready_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;

    // ------------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------------
    logic             aw_hs;
    logic             w_hs;
    logic             commit;
    logic [AW-1:0]    eff_addr;
    logic [DW-1:0]    eff_data;
    logic [SW-1:0]    eff_strb;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_ok;

    assign aw_hs = S_AXI_AWVALID && awready_q;
    assign w_hs  = S_AXI_WVALID  && wready_q;

    // The commit uses the latched half if one is held, otherwise the beat
    // on the bus, so a same-cycle AW+W commits on the handshake edge itself.
    assign eff_addr = (wr_state_q == WR_HAVE_AW) ? aw_addr_q : S_AXI_AWADDR;
    assign eff_data = (wr_state_q == WR_HAVE_W)  ? w_data_q  : S_AXI_WDATA;
    assign eff_strb = (wr_state_q == WR_HAVE_W)  ? w_strb_q  : S_AXI_WSTRB;
    assign wr_idx   = eff_addr[AW-1:2];
    assign wr_ok    = (wr_idx < WCOUNT_IDX);

    always_comb begin
        wr_state_d = wr_state_q;
        aw_addr_d  = aw_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bresp_d    = bresp_q;
        commit     = 1'b0;

        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                end else if (aw_hs) begin
                    wr_state_d = WR_HAVE_AW;
                    aw_addr_d  = S_AXI_AWADDR;
                end else if (w_hs) begin
                    wr_state_d = WR_HAVE_W;
                    w_data_d   = S_AXI_WDATA;
                    w_strb_d   = S_AXI_WSTRB;
                end
            end
            WR_HAVE_AW: if (w_hs)  commit = 1'b1;
            WR_HAVE_W:  if (aw_hs) commit = 1'b1;
            WR_RESP:    if (S_AXI_BREADY) wr_state_d = WR_IDLE;
            default:    wr_state_d = WR_IDLE;
        endcase

        if (commit) begin
            wr_state_d = WR_RESP;
            bresp_d    = wr_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Ready for a half only when that half is not held and no response waits.
    assign awready_d = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_W);
    assign wready_d  = (wr_state_d == WR_IDLE) || (wr_state_d == WR_HAVE_AW);

    // Register file and counter update; undecoded/WCOUNT writes change nothing.
    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_d[k] = regs_q[k];
        end
        wcount_d = wcount_q;
        if (commit && wr_ok) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_idx == IDX_W'(k)) begin
                    for (int b = 0; b < SW; b++) begin
                        if (eff_strb[b]) begin
                            regs_d[k][8*b +: 8] = eff_data[8*b +: 8];
                        end
                    end
                end
            end
            wcount_d = wcount_q + DW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------------
    logic             ar_hs;
    logic [IDX_W-1:0] rd_idx;

    assign ar_hs  = S_AXI_ARVALID && arready_q;
    assign rd_idx = S_AXI_ARADDR[AW-1:2];

    // Data is taken from regs_q, so a write committing on the same edge as
    // the AR handshake is not visible to this read.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = RD_RESP;
                    rdata_d    = '0;
                    rresp_d    = RESP_SLVERR;
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (rd_idx == IDX_W'(k)) begin
                            rdata_d = regs_q[k];
                            rresp_d = RESP_OKAY;
                        end
                    end
                    if (rd_idx == WCOUNT_IDX) begin
                        rdata_d = wcount_q;
                        rresp_d = RESP_OKAY;
                    end
                end
            end
            RD_RESP: if (S_AXI_RREADY) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    assign arready_d = (rd_state_d == RD_IDLE);

    // ------------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bresp_q    <= RESP_OKAY;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            wcount_q   <= '0;
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bresp_q    <= bresp_d;
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= regs_d[k];
            end
            wcount_q   <= wcount_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = (rd_state_q == RD_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

    // PROT and the byte offset within a word carry no meaning here.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], eff_addr[1:0]};

endmodule

// File: tb/tb_axilite_regfile_slave.sv
module tb_axilite_regfile_slave;

  // clock / reset
  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  logic [4:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  axilite_regfile_slave dut (
    .ACLK          (aclk),
    .ARESETN       (aresetn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: plain array of registers plus write count
  logic [31:0] m_regs [4];
  logic [31:0] m_wcount;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 32'h0;
    m_wcount = 32'h0;
  endtask

  task automatic model_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    int idx;
    logic [31:0] mask;
    idx  = int'(addr) / 4;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
    if (idx < 4) begin
      m_regs[idx] = (m_regs[idx] & ~mask) | (data & mask);
      m_wcount    = m_wcount + 32'd1;
      resp = 2'b00;
    end else begin
      resp = 2'b10;
    end
  endtask

  task automatic model_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
    int idx;
    idx = int'(addr) / 4;
    if (idx < 4) begin
      data = m_regs[idx]; resp = 2'b00;
    end else if (idx == 4) begin
      data = m_wcount; resp = 2'b00;
    end else begin
      data = 32'h0; resp = 2'b10;
    end
  endtask

  // driver: write with independent AW/W start delays and a BREADY hold-off
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          input int bhold, output logic [1:0] resp_obs);
    logic [1:0] exp_resp;
    bit aw_done, w_done, aw_fire, w_fire;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge aclk);
      if (aw_done != w_done) check("wr_no_early_bvalid", {31'b0, bvalid}, 32'd0);
      awvalid = !aw_done && (cyc >= aw_dly);
      awaddr  = addr;
      wvalid  = !w_done && (cyc >= w_dly);
      wdata   = data;
      wstrb   = strb;
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge aclk);
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done  = 1;
      cyc++;
    end
    check("wr_handshake_done", {31'b0, aw_done && w_done}, 32'd1);
    model_write(addr, data, strb, exp_resp);
    @(negedge aclk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("wr_bvalid_next_cycle", {31'b0, bvalid}, 32'd1);
    check("wr_bresp", {30'b0, bresp}, {30'b0, exp_resp});
    check("wr_awready_low_in_resp", {31'b0, awready}, 32'd0);
    resp_obs = bresp;
    for (int i = 0; i < bhold; i++) begin
      @(negedge aclk);
      check("wr_bvalid_hold", {31'b0, bvalid}, 32'd1);
      check("wr_bresp_hold", {30'b0, bresp}, {30'b0, exp_resp});
    end
    bready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    bready = 1'b0;
    check("wr_bvalid_cleared", {31'b0, bvalid}, 32'd0);
    check("wr_ready_back", {30'b0, awready, wready}, 32'd3);
  endtask

  // driver: read with an RREADY hold-off; returns the observed data
  task automatic do_read(input logic [4:0] addr, input int rhold,
                         output logic [31:0] data_obs, output logic [1:0] resp_obs);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    bit done, fire;
    int cyc;
    done = 0; cyc = 0;
    model_read(addr, exp_data, exp_resp);
    while (!done && cyc < 40) begin
      @(negedge aclk);
      arvalid = 1'b1;
      araddr  = addr;
      fire    = arready;
      @(posedge aclk);
      if (fire) done = 1;
      cyc++;
    end
    check("rd_handshake_done", {31'b0, done}, 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    check("rd_rvalid_next_cycle", {31'b0, rvalid}, 32'd1);
    check("rd_rdata", rdata, exp_data);
    check("rd_rresp", {30'b0, rresp}, {30'b0, exp_resp});
    data_obs = rdata;
    resp_obs = rresp;
    for (int i = 0; i < rhold; i++) begin
      @(negedge aclk);
      check("rd_rvalid_hold", {31'b0, rvalid}, 32'd1);
      check("rd_rdata_hold", rdata, exp_data);
    end
    rready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    rready = 1'b0;
    check("rd_rvalid_cleared", {31'b0, rvalid}, 32'd0);
    check("rd_arready_back", {31'b0, arready}, 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [31:0] old_val;
    logic [4:0]  a;

    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    model_reset();

    // reset state
    #12;
    check("rst_readies", {29'b0, awready, wready, arready}, 32'd0);
    check("rst_valids", {30'b0, bvalid, rvalid}, 32'd0);
    check("rst_resps", {28'b0, bresp, rresp}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    check("rel_readies_before_edge", {29'b0, awready, wready, arready}, 32'd0);
    @(negedge aclk);
    check("rel_readies_after_edge", {29'b0, awready, wready, arready}, 32'd7);

    // sequential write / readback of the four registers and WCOUNT
    for (int i = 0; i < 4; i++) begin
      do_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0, r);
      check("seq_wr_bresp_okay", {30'b0, r}, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      do_read(5'(4 * i), 0, d, r);
      check("seq_rd_value", d, 32'(i + 1));
    end
    do_read(5'h10, 0, d, r);
    check("seq_wcount_4", d, 32'd4);

    // byte strobes
    do_write(5'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0, r);
    do_write(5'h04, 32'h11223344, 4'b0101, 0, 0, 0, r);
    do_read(5'h04, 1, d, r);
    check("strb_merge", d, 32'hAA22CC44);
    do_write(5'h04, 32'hFFFFFFFF, 4'h0, 0, 0, 0, r);
    check("strb_zero_okay", {30'b0, r}, 32'd0);
    do_read(5'h04, 0, d, r);
    check("strb_zero_nochange", d, 32'hAA22CC44);

    // W ahead of AW, then AW ahead of W, slow BREADY
    do_write(5'h0C, 32'h0000_00C3, 4'hF, 3, 0, 5, r);
    check("w_first_okay", {30'b0, r}, 32'd0);
    do_write(5'h0C, 32'h0000_00C4, 4'hF, 0, 3, 5, r);
    check("aw_first_okay", {30'b0, r}, 32'd0);
    do_read(5'h0C, 0, d, r);
    check("aw_first_data", d, 32'h0000_00C4);
    do_read(5'h10, 0, d, r);
    check("wcount_after_split", d, 32'd9);

    // undecoded and read-only targets
    do_write(5'h10, 32'h12345678, 4'hF, 0, 0, 0, r);
    check("wr_wcount_slverr", {30'b0, r}, 32'd2);
    do_write(5'h18, 32'h12345678, 4'hF, 1, 0, 0, r);
    check("wr_undec_slverr", {30'b0, r}, 32'd2);
    do_read(5'h10, 0, d, r);
    check("wcount_unchanged", d, 32'd9);
    do_read(5'h18, 0, d, r);
    check("rd_undec_slverr", {30'b0, r}, 32'd2);
    check("rd_undec_zero", d, 32'd0);

    // restore reg 2 to 3 then read on the same edge a write commits
    do_write(5'h08, 32'd3, 4'hF, 0, 0, 0, r);
    @(negedge aclk);
    check("same_edge_readies", {29'b0, awready, wready, arready}, 32'd7);
    old_val = m_regs[2];
    awvalid = 1; awaddr = 5'h08; wvalid = 1; wdata = 32'h55; wstrb = 4'hF;
    arvalid = 1; araddr = 5'h08;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    model_write(5'h08, 32'h55, 4'hF, r);
    check("same_edge_rvalid", {31'b0, rvalid}, 32'd1);
    check("same_edge_old_data", rdata, old_val);
    check("same_edge_old_is_3", rdata, 32'd3);
    check("same_edge_bvalid", {31'b0, bvalid}, 32'd1);
    bready = 1; rready = 1;
    @(posedge aclk);
    @(negedge aclk);
    bready = 0; rready = 0;
    do_read(5'h08, 0, d, r);
    check("same_edge_new_data", d, 32'h55);

    // randomized mix against the model
    for (int n = 0; n < 40; n++) begin
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2), r);
      else
        do_read(a, $urandom_range(0, 2), d, r);
    end
    do_read(5'h10, 0, d, r);

    // reset while both responses are pending
    @(negedge aclk);
    awvalid = 1; awaddr = 5'h00; wvalid = 1; wdata = 32'hDEAD; wstrb = 4'hF;
    arvalid = 1; araddr = 5'h00;
    @(posedge aclk);
    @(negedge aclk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("pend_valids", {30'b0, bvalid, rvalid}, 32'd3);
    #2 aresetn = 1'b0;
    #1;
    check("mid_rst_valids_drop", {30'b0, bvalid, rvalid}, 32'd0);
    check("mid_rst_readies_low", {29'b0, awready, wready, arready}, 32'd0);
    model_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 5; i++) begin
      do_read(5'(4 * i), 0, d, r);
      check("post_rst_zero", d, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
